sipo_operand_loader: RTL and testbench
======================================

// Module: sipo_operand_loader
// PURPOSE
//   Sequencer that deserialises two multiplier operands from one serial input.
//   Operand A arrives first, then operand B, each WIDTH bits long, MSB first.
//   It drives two internal shift-in registers, counts bits and tracks which operand
//   is loading. It then presents {op_a, op_b} to the 16-bit multiplier core with a
//   valid/ready handshake. It sits between the serial link front-end and the multiplier.
// PARAMETERS
//   WIDTH   16   operand width in bits; legal range 2..32
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-low reset, sampled on rising edge of clk
//   start      in   1       request a new operand pair (single-cycle pulse)
//   abort      in   1       cancel any load in progress
//   bit_in     in   1       serial data bit
//   bit_en     in   1       bit_in qualifier; a bit is consumed only when high
//   out_ready  in   1       multiplier accepts op_a/op_b this cycle
//   op_a       out  WIDTH   deserialised operand A
//   op_b       out  WIDTH   deserialised operand B
//   out_valid  out  1       op_a/op_b complete and stable
//   busy       out  1       high in LOAD_A, LOAD_B and VALID
//   loading_b  out  1       high only in LOAD_B
//   err        out  1       one-cycle pulse: start received while busy
// BEHAVIOUR
// - Reset (rst==0 at a clk edge):
//   - state=IDLE; op_a, op_b and the bit counter are 0.
//   - out_valid, busy, loading_b and err are 0.
//   - Reset overrides every other input and takes effect mid-load or mid-handshake.
// - States: IDLE -> LOAD_A -> LOAD_B -> VALID -> IDLE.
// - IDLE:
//   - bit_en is ignored.
//   - start=1 -> LOAD_A, counter cleared; op_a and op_b keep their values until the first shift.
//   - No bit is consumed in the start cycle.
// - LOAD_A:
//   - When bit_en=1: op_a <= {op_a[WIDTH-2:0], bit_in} and counter++.
//   - On the WIDTH-th consumed bit: -> LOAD_B, counter cleared.
//   - bit_en=0 stalls indefinitely; there is no timeout.
// - LOAD_B: identical to LOAD_A, shifting into op_b. On the WIDTH-th bit: -> VALID.
// - VALID:
//   - out_valid=1; op_a and op_b are held constant.
//   - bit_en is ignored.
//   - out_ready=1 -> IDLE next cycle, out_valid=0.
//   - out_ready=1 and start=1 in the same cycle -> LOAD_A directly (back-to-back); no err.
// - Latency: with continuous bit_en, start at cycle 0 gives bits in cycles 1..2*WIDTH
//   and out_valid=1 from cycle 2*WIDTH+1.
// - Counter: width $clog2(WIDTH)+1. It wraps only through the explicit clear; it never overflows.
// - Start while busy (LOAD_A, LOAD_B, or VALID without out_ready):
//   - start is ignored; err=1 for exactly the next cycle.
//   - The load in progress is unaffected.
// - Abort:
//   - In any non-IDLE state: -> IDLE next cycle; counter, op_a, op_b and out_valid cleared.
//   - Abort has priority over start, bit_en and out_ready in the same cycle; no err is raised.
//   - Abort in IDLE has no effect.
// - Outputs are registered; no combinational path from inputs to outputs.
// TESTING
// 1. Reset: hold rst=0 for 2 clks with start=1 and bit_en=1
//    -> all outputs 0; state IDLE after release.
// 2. Basic load (WIDTH=16): start, then 32 contiguous bits 0x1234 then 0xABCD, MSB first
//    -> out_valid at cycle 33; op_a=0x1234, op_b=0xABCD; loading_b high during cycles 17..32.
// 3. Stalls and backpressure: same data with bit_en low every 3rd cycle, out_ready held low
//    10 cycles -> identical operands, which stay stable; out_valid drops one cycle after out_ready=1.
// 4. Back-to-back: out_ready and start in the same cycle, then 0xFFFF/0x0001
//    -> no IDLE gap, err=0, second pair correct.
// 5. Errors: start at bit 5 of A -> err one cycle, load completes correctly.
//    abort at bit 3 of B -> IDLE, op_a=op_b=0, out_valid never asserted.
// 6. Reset mid-VALID with out_ready=0 -> out_valid=0 next cycle; a fresh load of 0x8000/0x7FFF succeeds.

Source files
------------

// File: rtl/sipo_operand_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sipo_operand_loader                                           |
// | Purpose  : Deserialises two WIDTH-bit operands (A then B, MSB first)     |
// |            from one serial input. It then presents them to the          |
// |            multiplier core through a valid/ready handshake.             |
// | Ports    : clk, rst (sync, active-low)                                   |
// |            start, abort         - sequence control                      |
// |            bit_in, bit_en       - qualified serial data                 |
// |            out_ready            - multiplier accepts the operand pair   |
// |            op_a, op_b           - deserialised operands                 |
// |            out_valid, busy, loading_b, err - registered status          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sipo_operand_loader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic             busy,
  output logic             loading_b,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_load_a = 2'd1;
  localparam logic [1:0] c_st_load_b = 2'd2;
  localparam logic [1:0] c_st_valid  = 2'd3;

  // Count value of the last bit of an operand; the counter is cleared
  // there instead of incrementing, so it never reaches WIDTH.
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

  logic [1:0]       state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] op_a_q,      op_a_d;
  logic [WIDTH-1:0] op_b_q,      op_b_d;
  logic             err_q,       err_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;
  logic             loading_b_q, loading_b_d;

  // State and datapath register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= c_st_idle;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      loading_b_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      loading_b_q <= loading_b_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    err_d   = 1'b0;

    if (abort && (state_q != c_st_idle)) begin
      // Abort wins over start, bit_en and out_ready and never flags err.
      state_d = c_st_idle;
      cnt_d   = '0;
      op_a_d  = '0;
      op_b_d  = '0;
    end else begin
      case (state_q)
        c_st_idle: begin
          if (start) begin
            state_d = c_st_load_a;
            cnt_d   = '0;
          end
        end

        c_st_load_a: begin
          err_d = start;
          if (bit_en) begin
            op_a_d = {op_a_q[WIDTH-2:0], bit_in};
            if (cnt_q == c_cnt_last) begin
              state_d = c_st_load_b;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end

        c_st_load_b: begin
          err_d = start;
          if (bit_en) begin
            op_b_d = {op_b_q[WIDTH-2:0], bit_in};
            if (cnt_q == c_cnt_last) begin
              state_d = c_st_valid;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end

        c_st_valid: begin
          if (out_ready) begin
            // A start coinciding with the handshake chains the next load
            // without an idle gap and is not an error.
            if (start) begin
              state_d = c_st_load_a;
              cnt_d   = '0;
            end else begin
              state_d = c_st_idle;
            end
          end else begin
            err_d = start;
          end
        end

        default: begin
          state_d = c_st_idle;
        end
      endcase
    end
  end

  // Output decode of the next state, so status flags register alongside it.
  always_comb begin
    out_valid_d = (state_d == c_st_valid);
    busy_d      = (state_d != c_st_idle);
    loading_b_d = (state_d == c_st_load_b);
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign loading_b = loading_b_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_operand_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sipo_operand_loader                                        |
// | Purpose  : Directed self-checking bench for sipo_operand_loader (W=16).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sipo_operand_loader;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             bit_in;
  logic             bit_en;
  logic             out_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             busy;
  logic             loading_b;
  logic             err;

  int n_total = 0;
  int n_bad   = 0;

  sipo_operand_loader #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .out_ready (out_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .busy      (busy),
    .loading_b (loading_b),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift one operand MSB first; with stall set, bit_en drops for a cycle
  // before every third bit.
  task automatic shift_word(input logic [15:0] w, input bit stall);
    for (int i = 15; i >= 0; i--) begin
      if (stall && (i % 3 == 0)) begin
        bit_en = 1'b0;
        bit_in = 1'b1;
        tick();
      end
      bit_en = 1'b1;
      bit_in = w[i];
      tick();
    end
    bit_en = 1'b0;
  endtask

  task automatic load_pair(input logic [15:0] a, input logic [15:0] b, input bit stall);
    start = 1'b1;
    tick();
    start = 1'b0;
    shift_word(a, stall);
    shift_word(b, stall);
  endtask

  initial begin
    start = 1'b1; abort = 1'b0; bit_in = 1'b1; bit_en = 1'b1;
    out_ready = 1'b0; rst = 1'b0;

    // 1. Reset with start/bit_en active.
    tick(); tick();
    chk("rst_op_a", 32'(op_a), 32'h0);
    chk("rst_op_b", 32'(op_b), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_loadb", 32'(loading_b), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    start = 1'b0; bit_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_after_rst", 32'(busy), 32'h0);
    // bit_en in IDLE is ignored.
    bit_en = 1'b1; bit_in = 1'b1;
    tick(); tick();
    chk("idle_ignore_bits", 32'(op_a), 32'h0);
    bit_en = 1'b0;

    // 2. Basic load with exact cycle timing.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_loadb", 32'(loading_b), 32'h0);
    for (int i = 15; i >= 0; i--) begin
      bit_en = 1'b1; bit_in = 16'h1234 >> i;
      tick();
      if (i == 1) chk("a_last_minus1_loadb", 32'(loading_b), 32'h0);
    end
    chk("a_done_loadb", 32'(loading_b), 32'h1);
    chk("a_done_op_a", 32'(op_a), 32'h1234);
    for (int i = 15; i >= 0; i--) begin
      bit_in = 16'hABCD >> i;
      tick();
      if (i == 1) begin
        chk("b_last_minus1_valid", 32'(out_valid), 32'h0);
        chk("b_last_minus1_loadb", 32'(loading_b), 32'h1);
      end
    end
    bit_en = 1'b0;
    chk("basic_valid", 32'(out_valid), 32'h1);
    chk("basic_loadb", 32'(loading_b), 32'h0);
    chk("basic_op_a", 32'(op_a), 32'h1234);
    chk("basic_op_b", 32'(op_b), 32'hABCD);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_release_valid", 32'(out_valid), 32'h0);
    chk("basic_release_busy", 32'(busy), 32'h0);
    chk("basic_hold_op_b", 32'(op_b), 32'hABCD);

    // 3. Stalls and backpressure; bits during VALID are ignored.
    load_pair(16'h1234, 16'hABCD, 1'b1);
    chk("stall_valid", 32'(out_valid), 32'h1);
    for (int k = 0; k < 10; k++) begin
      bit_en = 1'b1; bit_in = k[0];
      tick();
    end
    bit_en = 1'b0;
    chk("bp_op_a", 32'(op_a), 32'h1234);
    chk("bp_op_b", 32'(op_b), 32'hABCD);
    chk("bp_valid", 32'(out_valid), 32'h1);
    // Start in VALID without out_ready is an error and is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("valid_start_err", 32'(err), 32'h1);
    chk("valid_start_held", 32'(out_valid), 32'h1);
    tick();
    chk("valid_err_one_cycle", 32'(err), 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'h0);

    // 4. Back-to-back: handshake and start together.
    load_pair(16'h1111, 16'h2222, 1'b0);
    chk("b2b_first_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'h1);
    chk("b2b_valid_drop", 32'(out_valid), 32'h0);
    chk("b2b_no_err", 32'(err), 32'h0);
    shift_word(16'hFFFF, 1'b0);
    shift_word(16'h0001, 1'b0);
    chk("b2b_op_a", 32'(op_a), 32'hFFFF);
    chk("b2b_op_b", 32'(op_b), 32'h0001);
    chk("b2b_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 5a. Start during A, at the 6th bit: err for one cycle, load unaffected.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      start = (i == 10);
      bit_en = 1'b1; bit_in = 16'h5A5A >> i;
      tick();
      if (i == 10) chk("errA_pulse", 32'(err), 32'h1);
      if (i == 9)  chk("errA_one_cycle", 32'(err), 32'h0);
    end
    start = 1'b0;
    shift_word(16'hC3C3, 1'b0);
    chk("errA_op_a", 32'(op_a), 32'h5A5A);
    chk("errA_op_b", 32'(op_b), 32'hC3C3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 5b. Abort at bit 3 of B, together with start and bit_en.
    start = 1'b1;
    tick();
    start = 1'b0;
    shift_word(16'h1234, 1'b0);
    for (int i = 15; i >= 13; i--) begin
      bit_en = 1'b1; bit_in = 16'hFFFF >> i;
      tick();
    end
    abort = 1'b1; start = 1'b1; bit_in = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_op_a", 32'(op_a), 32'h0);
    chk("abort_op_b", 32'(op_b), 32'h0);
    chk("abort_err", 32'(err), 32'h0);
    begin
      logic seen_valid;
      seen_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick();
        seen_valid = seen_valid | out_valid;
      end
      chk("abort_never_valid", 32'(seen_valid), 32'h0);
    end
    bit_en = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_noop", 32'(busy), 32'h0);

    // 6. Reset while VALID, then a fresh load.
    load_pair(16'h0F0F, 16'hF0F0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_op_a", 32'(op_a), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    load_pair(16'h8000, 16'h7FFF, 1'b0);
    chk("fresh_valid", 32'(out_valid), 32'h1);
    chk("fresh_op_a", 32'(op_a), 32'h8000);
    chk("fresh_op_b", 32'(op_b), 32'h7FFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
